// File: rtl/dhcp_pkg.sv
// dhcp_pkg: DHCP opcodes, message types, option codes, ports,
// tx FSM encoding, the reply field bundle and byte-pick helpers.
package dhcp_pkg;

   localparam logic [7:0] OP_BOOTREQUEST = 8'h01;
   localparam logic [7:0] OP_BOOTREPLY   = 8'h02;
   localparam logic [7:0] HTYPE_ETH      = 8'h01;
   localparam logic [7:0] HLEN_ETH       = 8'h06;

   localparam logic [7:0] MSG_DISCOVER = 8'h01;
   localparam logic [7:0] MSG_OFFER    = 8'h02;
   localparam logic [7:0] MSG_REQUEST  = 8'h03;
   localparam logic [7:0] MSG_ACK      = 8'h05;
   localparam logic [7:0] MSG_NAK      = 8'h06;

   localparam logic [31:0] DHCP_COOKIE = 32'h6382_5363;

   localparam logic [7:0] OPT_SUBNET    = 8'd1;
   localparam logic [7:0] OPT_REQ_IP    = 8'd50;
   localparam logic [7:0] OPT_LEASE     = 8'd51;
   localparam logic [7:0] OPT_MSG_TYPE  = 8'd53;
   localparam logic [7:0] OPT_SERVER_ID = 8'd54;
   localparam logic [7:0] OPT_END       = 8'd255;
   localparam logic [7:0] OPT_LEN_4     = 8'h04;

   localparam logic [15:0] PORT_SERVER = 16'd67;
   localparam logic [15:0] PORT_CLIENT = 16'd68;

   localparam logic [8:0] RX_CNT_MAX   = 9'd511;
   localparam logic [8:0] RX_MIN_LEN   = 9'd243;
   localparam logic [8:0] RX_OPT50_END = 9'd249;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_ARM  = 2'd1,
      TX_SEND = 2'd2
   } tx_state_t;

   typedef struct packed {
      logic [31:0] xid;
      logic [47:0] chaddr;
      logic [31:0] yiaddr;
      logic [7:0]  msg_type;
   } reply_t;

   function automatic logic [7:0] pick32(
      input logic [31:0] w,
      input logic [1:0]  k
   );
      logic [7:0] b;
      unique case (k)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

   function automatic logic [7:0] pick48(
      input logic [47:0] w,
      input logic [2:0]  k
   );
      logic [7:0] b;
      unique case (k)
         3'd0:    b = w[47:40];
         3'd1:    b = w[39:32];
         3'd2:    b = w[31:24];
         3'd3:    b = w[23:16];
         3'd4:    b = w[15:8];
         3'd5:    b = w[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/dhcp_request_parser.sv
// dhcp_request_parser: counts port-67 payload bytes, captures xid/chaddr
// and requested IP, validates the header, and flags a commit on rx end.
// Ports: clock, reset(n), enable, rx_data/rx_enable, dhcp_rx_active,
//        offer_ip in; commit, parsed (reply fields) out.
module dhcp_request_parser
   import dhcp_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  rx_data,
   input  logic        rx_enable,
   input  logic        dhcp_rx_active,
   input  logic [31:0] offer_ip,
   output logic        commit,
   output reply_t      parsed
);

   logic [8:0]  cnt;
   logic        active_q;
   logic        bad;
   logic        opt50;
   logic        is_request;
   logic [31:0] xid;
   logic [47:0] chaddr;
   logic [31:0] req_ip;
   logic        have_req;
   logic        req_match;
   logic [7:0]  msg_type;

   // bad resets to 1 so a datagram already in flight when reset
   // releases is never committed; it clears on the next idle gap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         active_q   <= 1'b0;
         bad        <= 1'b1;
         opt50      <= 1'b0;
         is_request <= 1'b0;
         xid        <= '0;
         chaddr     <= '0;
         req_ip     <= '0;
      end else begin
         active_q <= dhcp_rx_active;
         if (!dhcp_rx_active) begin
            cnt        <= '0;
            bad        <= 1'b0;
            opt50      <= 1'b0;
            is_request <= 1'b0;
         end else if (rx_enable) begin
            if (cnt != RX_CNT_MAX)
               cnt <= cnt + 9'd1;
            unique case (1'b1)
               cnt == 9'd0: begin
                  if (rx_data != OP_BOOTREQUEST)
                     bad <= 1'b1;
               end
               cnt >= 9'd4 && cnt <= 9'd7:
                  xid <= {xid[23:0], rx_data};
               cnt >= 9'd28 && cnt <= 9'd33:
                  chaddr <= {chaddr[39:0], rx_data};
               cnt >= 9'd236 && cnt <= 9'd239: begin
                  if (rx_data != pick32(DHCP_COOKIE, cnt[1:0]))
                     bad <= 1'b1;
               end
               cnt == 9'd240: begin
                  if (rx_data != OPT_MSG_TYPE)
                     bad <= 1'b1;
               end
               cnt == 9'd241: begin
                  if (rx_data != 8'h01)
                     bad <= 1'b1;
               end
               cnt == 9'd242: begin
                  if (rx_data == MSG_REQUEST)
                     is_request <= 1'b1;
                  else if (rx_data != MSG_DISCOVER)
                     bad <= 1'b1;
               end
               cnt == 9'd243:
                  opt50 <= (rx_data == OPT_REQ_IP);
               cnt == 9'd244: begin
                  if (rx_data != OPT_LEN_4)
                     opt50 <= 1'b0;
               end
               cnt >= 9'd245 && cnt <= 9'd248:
                  req_ip <= {req_ip[23:0], rx_data};
               default: ;
            endcase
         end
      end
   end

   // Option 50 only counts once all four address bytes arrived.
   assign have_req  = opt50 && (cnt >= RX_OPT50_END);
   assign req_match = (have_req ? req_ip : offer_ip) == offer_ip;

   always_comb begin
      msg_type = MSG_OFFER;
      if (is_request)
         msg_type = req_match ? MSG_ACK : MSG_NAK;
   end

   assign commit = active_q && !dhcp_rx_active && enable &&
                   !bad && (cnt >= RX_MIN_LEN);

   assign parsed.xid      = xid;
   assign parsed.chaddr   = chaddr;
   assign parsed.yiaddr   = (msg_type == MSG_NAK) ? 32'h0 : offer_ip;
   assign parsed.msg_type = msg_type;

endmodule

// File: rtl/dhcp_server_responder.sv
// dhcp_server_responder: minimal DHCP server; turns DISCOVER/REQUEST into
// OFFER/ACK/NAK streamed to UDP tx (broadcast, port 68).
// Ports: clock, reset(n), enable, rx stream, server/offer IP, udp tx
//        grant/active in; request, tx_data, length, destination,
//        client_mac, bound and event pulses out.
module dhcp_server_responder
   import dhcp_pkg::*;
#(
   parameter logic [31:0] LEASE_SECONDS = 32'd86400,
   parameter logic [31:0] SUBNET_MASK   = 32'hFFFF_FF00,
   parameter logic [15:0] REPLY_LEN     = 16'd262
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  rx_data,
   input  logic        rx_enable,
   input  logic        dhcp_rx_active,
   input  logic [31:0] server_ip,
   input  logic [31:0] offer_ip,
   input  logic        udp_tx_enable,
   input  logic        udp_tx_active,
   output logic        dhcp_tx_request,
   output logic [7:0]  tx_data,
   output logic [15:0] length,
   output logic [47:0] dhcp_destination_mac,
   output logic [31:0] dhcp_destination_ip,
   output logic [15:0] dhcp_destination_port,
   output logic [47:0] client_mac,
   output logic        bound,
   output logic        offer_sent,
   output logic        ack_sent,
   output logic        nak_sent,
   output logic        dropped
);

   logic      commit;
   reply_t    parsed;
   reply_t    rep;
   tx_state_t state, state_n;
   logic [15:0] idx, idx_n;
   logic [7:0]  data, data_n;
   logic      accept;
   logic      drop;
   logic      done;

   dhcp_request_parser u_parser (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .rx_data        (rx_data),
      .rx_enable      (rx_enable),
      .dhcp_rx_active (dhcp_rx_active),
      .offer_ip       (offer_ip),
      .commit         (commit),
      .parsed         (parsed)
   );

   function automatic logic [7:0] reply_byte(
      input logic [15:0] i,
      input reply_t      r,
      input logic [31:0] sip
   );
      logic [7:0] b;
      b = 8'h00;
      unique case (1'b1)
         i == 16'd0: b = OP_BOOTREPLY;
         i == 16'd1: b = HTYPE_ETH;
         i == 16'd2: b = HLEN_ETH;
         i >= 16'd4 && i <= 16'd7:
            b = pick32(r.xid, 2'(i - 16'd4));
         i >= 16'd16 && i <= 16'd19:
            b = pick32(r.yiaddr, 2'(i - 16'd16));
         i >= 16'd20 && i <= 16'd23:
            b = pick32(sip, 2'(i - 16'd20));
         i >= 16'd28 && i <= 16'd33:
            b = pick48(r.chaddr, 3'(i - 16'd28));
         i >= 16'd236 && i <= 16'd239:
            b = pick32(DHCP_COOKIE, 2'(i - 16'd236));
         i == 16'd240: b = OPT_MSG_TYPE;
         i == 16'd241: b = 8'h01;
         i == 16'd242: b = r.msg_type;
         i == 16'd243: b = OPT_SERVER_ID;
         i == 16'd244: b = OPT_LEN_4;
         i >= 16'd245 && i <= 16'd248:
            b = pick32(sip, 2'(i - 16'd245));
         i == 16'd249: b = OPT_LEASE;
         i == 16'd250: b = OPT_LEN_4;
         i >= 16'd251 && i <= 16'd254:
            b = pick32(LEASE_SECONDS, 2'(i - 16'd251));
         i == 16'd255: b = OPT_SUBNET;
         i == 16'd256: b = OPT_LEN_4;
         i >= 16'd257 && i <= 16'd260:
            b = pick32(SUBNET_MASK, 2'(i - 16'd257));
         i == 16'd261: b = OPT_END;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign accept = commit && (state == TX_IDLE);
   assign drop   = commit && (state != TX_IDLE);

   always_comb begin
      state_n = state;
      idx_n   = idx;
      data_n  = data;
      done    = 1'b0;
      unique case (state)
         TX_IDLE: begin
            if (accept)
               state_n = TX_ARM;
         end
         TX_ARM: begin
            if (udp_tx_enable && enable) begin
               state_n = TX_SEND;
               idx_n   = 16'd0;
               data_n  = reply_byte(16'd0, rep, server_ip);
            end
         end
         TX_SEND: begin
            // Index only advances on consumed cycles, so a stall
            // in udp_tx_active neither skips nor repeats a byte.
            if (udp_tx_active) begin
               if (idx == REPLY_LEN - 16'd1) begin
                  state_n = TX_IDLE;
                  idx_n   = 16'd0;
                  data_n  = 8'h00;
                  done    = 1'b1;
               end else begin
                  idx_n  = idx + 16'd1;
                  data_n = reply_byte(idx + 16'd1, rep, server_ip);
               end
            end
         end
         default: state_n = TX_IDLE;
      endcase
   end

   // rep is loaded only on accept, so fields stay frozen while the
   // reply is pending or streaming even if new packets arrive.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= TX_IDLE;
         idx        <= '0;
         data       <= '0;
         rep        <= '0;
         offer_sent <= 1'b0;
         ack_sent   <= 1'b0;
         nak_sent   <= 1'b0;
         dropped    <= 1'b0;
         client_mac <= '0;
         bound      <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         data       <= data_n;
         if (accept)
            rep <= parsed;
         offer_sent <= done && (rep.msg_type == MSG_OFFER);
         ack_sent   <= done && (rep.msg_type == MSG_ACK);
         nak_sent   <= done && (rep.msg_type == MSG_NAK);
         dropped    <= drop;
         if (done && rep.msg_type == MSG_ACK) begin
            client_mac <= rep.chaddr;
            bound      <= 1'b1;
         end
      end
   end

   assign dhcp_tx_request       = (state != TX_IDLE);
   assign tx_data               = data;
   assign length                = REPLY_LEN;
   assign dhcp_destination_mac  = 48'hFFFF_FFFF_FFFF;
   assign dhcp_destination_ip   = 32'hFFFF_FFFF;
   assign dhcp_destination_port = PORT_CLIENT;

endmodule

// File: tb/tb_dhcp_server_responder.sv
// tb_dhcp_server_responder: directed bench for the DHCP responder
// (offer, ack, nak, discards, busy drop, reset mid-reply).
module tb_dhcp_server_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_enable = 1'b0;
   logic        dhcp_rx_active = 1'b0;
   logic [31:0] server_ip = 32'hA9FE_1301;
   logic [31:0] offer_ip = 32'hA9FE_13DD;
   logic        udp_tx_enable = 1'b0;
   logic        udp_tx_active = 1'b0;
   logic        dhcp_tx_request;
   logic [7:0]  tx_data;
   logic [15:0] length;
   logic [47:0] dhcp_destination_mac;
   logic [31:0] dhcp_destination_ip;
   logic [15:0] dhcp_destination_port;
   logic [47:0] client_mac;
   logic        bound;
   logic        offer_sent, ack_sent, nak_sent, dropped;

   int n_cmp = 0;
   int n_bad = 0;
   int n_offer = 0, n_ack = 0, n_nak = 0, n_drop = 0, n_req = 0;
   int first_diff = 0;

   logic [7:0] pkt   [0:299];
   logic [7:0] rbuf  [0:261];
   logic [7:0] exp_b [0:261];

   localparam logic [47:0] MAC1 = 48'h001C_C0A2_13DD;
   localparam logic [47:0] MAC2 = 48'h0211_2233_4455;

   dhcp_server_responder dut (
      .clock                 (clock),
      .reset                 (reset),
      .enable                (enable),
      .rx_data               (rx_data),
      .rx_enable             (rx_enable),
      .dhcp_rx_active        (dhcp_rx_active),
      .server_ip             (server_ip),
      .offer_ip              (offer_ip),
      .udp_tx_enable         (udp_tx_enable),
      .udp_tx_active         (udp_tx_active),
      .dhcp_tx_request       (dhcp_tx_request),
      .tx_data               (tx_data),
      .length                (length),
      .dhcp_destination_mac  (dhcp_destination_mac),
      .dhcp_destination_ip   (dhcp_destination_ip),
      .dhcp_destination_port (dhcp_destination_port),
      .client_mac            (client_mac),
      .bound                 (bound),
      .offer_sent            (offer_sent),
      .ack_sent              (ack_sent),
      .nak_sent              (nak_sent),
      .dropped               (dropped)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (offer_sent) n_offer++;
      if (ack_sent) n_ack++;
      if (nak_sent) n_nak++;
      if (dropped) n_drop++;
      if (dhcp_tx_request) n_req++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic build_pkt(
      input logic [7:0]  op,
      input logic [7:0]  mtype,
      input logic [31:0] xid,
      input logic [47:0] mac,
      input bit          opt50,
      input logic [31:0] rip
   );
      logic [31:0] ck;
      ck = 32'h6382_5363;
      for (int i = 0; i < 300; i++) pkt[i] = 8'h00;
      pkt[0] = op;
      pkt[1] = 8'h01;
      pkt[2] = 8'h06;
      for (int i = 0; i < 4; i++) begin
         pkt[4 + i]   = xid[31 - 8*i -: 8];
         pkt[236 + i] = ck[31 - 8*i -: 8];
         pkt[245 + i] = opt50 ? rip[31 - 8*i -: 8] : 8'h00;
      end
      for (int i = 0; i < 6; i++) pkt[28 + i] = mac[47 - 8*i -: 8];
      pkt[240] = 8'h35;
      pkt[241] = 8'h01;
      pkt[242] = mtype;
      if (opt50) begin
         pkt[243] = 8'h32;
         pkt[244] = 8'h04;
         pkt[249] = 8'hFF;
      end else begin
         pkt[243] = 8'hFF;
      end
   endtask

   task automatic send_pkt(input int len);
      @(negedge clock);
      dhcp_rx_active = 1'b1;
      for (int i = 0; i < len; i++) begin
         rx_enable = 1'b1;
         rx_data = pkt[i];
         @(negedge clock);
      end
      rx_enable = 1'b0;
      rx_data = 8'h00;
      dhcp_rx_active = 1'b0;
   endtask

   task automatic build_exp(
      input logic [7:0]  mtype,
      input logic [31:0] xid,
      input logic [47:0] mac,
      input logic [31:0] yi
   );
      logic [31:0] ck, lease, mask;
      ck = 32'h6382_5363;
      lease = 32'h0001_5180;
      mask = 32'hFFFF_FF00;
      for (int i = 0; i < 262; i++) exp_b[i] = 8'h00;
      exp_b[0] = 8'h02;
      exp_b[1] = 8'h01;
      exp_b[2] = 8'h06;
      for (int i = 0; i < 4; i++) begin
         exp_b[4 + i]   = xid[31 - 8*i -: 8];
         exp_b[16 + i]  = yi[31 - 8*i -: 8];
         exp_b[20 + i]  = server_ip[31 - 8*i -: 8];
         exp_b[236 + i] = ck[31 - 8*i -: 8];
         exp_b[245 + i] = server_ip[31 - 8*i -: 8];
         exp_b[251 + i] = lease[31 - 8*i -: 8];
         exp_b[257 + i] = mask[31 - 8*i -: 8];
      end
      for (int i = 0; i < 6; i++) exp_b[28 + i] = mac[47 - 8*i -: 8];
      exp_b[240] = 8'h35;
      exp_b[241] = 8'h01;
      exp_b[242] = mtype;
      exp_b[243] = 8'h36;
      exp_b[244] = 8'h04;
      exp_b[249] = 8'h33;
      exp_b[250] = 8'h04;
      exp_b[255] = 8'h01;
      exp_b[256] = 8'h04;
      exp_b[261] = 8'hFF;
   endtask

   function automatic int count_diff();
      int n;
      n = 0;
      first_diff = 0;
      for (int i = 0; i < 262; i++)
         if (rbuf[i] !== exp_b[i]) begin
            if (n == 0) first_diff = i;
            n++;
         end
      return n;
   endfunction

   // Acts as the UDP tx side: waits (bounded) for the request, grants
   // it, then consumes bytes; optional 3-cycle stall and early abort.
   task automatic rx_reply(input int gap_at, input int abort_at,
                           output bit got);
      got = 1'b0;
      for (int i = 0; i < 262; i++) rbuf[i] = 8'hxx;
      for (int w = 0; w < 20 && !dhcp_tx_request; w++)
         @(negedge clock);
      if (dhcp_tx_request) begin
         got = 1'b1;
         udp_tx_enable = 1'b1;
         @(negedge clock);
         udp_tx_enable = 1'b0;
         for (int k = 0; k < 262; k++) begin
            if (k == abort_at) break;
            if (k == gap_at) begin
               udp_tx_active = 1'b0;
               repeat (3) @(negedge clock);
            end
            udp_tx_active = 1'b1;
            rbuf[k] = tx_data;
            @(negedge clock);
         end
         if (abort_at >= 262) udp_tx_active = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_cmp++;
      if (dhcp_tx_request !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_req: got %b want 0", dhcp_tx_request);
      end
      n_cmp++;
      if (tx_data !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_tx_data: got %h want 00", tx_data);
      end
      n_cmp++;
      if (length !== 16'd262) begin
         n_bad++;
         $display("FAIL rst_length: got %0d want 262", length);
      end
      n_cmp++;
      if (dhcp_destination_mac !== 48'hFFFF_FFFF_FFFF) begin
         n_bad++;
         $display("FAIL rst_dmac: got %h want ffffffffffff",
                  dhcp_destination_mac);
      end
      n_cmp++;
      if (dhcp_destination_ip !== 32'hFFFF_FFFF) begin
         n_bad++;
         $display("FAIL rst_dip: got %h want ffffffff", dhcp_destination_ip);
      end
      n_cmp++;
      if (dhcp_destination_port !== 16'd68) begin
         n_bad++;
         $display("FAIL rst_dport: got %0d want 68", dhcp_destination_port);
      end
      n_cmp++;
      if (client_mac !== 48'h0) begin
         n_bad++;
         $display("FAIL rst_client_mac: got %h want 0", client_mac);
      end
      n_cmp++;
      if (bound !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_bound: got %b want 0", bound);
      end
      n_cmp++;
      if ({offer_sent, ack_sent, nak_sent, dropped} !== 4'b0000) begin
         n_bad++;
         $display("FAIL rst_pulses: got %b want 0000",
                  {offer_sent, ack_sent, nak_sent, dropped});
      end
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_offer();
      bit got;
      int o0, a0, k0;
      o0 = n_offer; a0 = n_ack; k0 = n_nak;
      build_pkt(8'h01, 8'h01, 32'hDEAD_BEEF, MAC1, 1'b0, 32'h0);
      send_pkt(244);
      rx_reply(1000, 1000, got);
      repeat (2) @(negedge clock);
      build_exp(8'h02, 32'hDEAD_BEEF, MAC1, offer_ip);
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL t1_request: got %b want 1", got);
      end
      n_cmp++;
      if (count_diff() !== 0) begin
         n_bad++;
         $display("FAIL t1_reply: byte %0d got %h want %h",
                  first_diff, rbuf[first_diff], exp_b[first_diff]);
      end
      n_cmp++;
      if (rbuf[242] !== 8'h02) begin
         n_bad++;
         $display("FAIL t1_type: got %h want 02", rbuf[242]);
      end
      n_cmp++;
      if ({rbuf[4], rbuf[5], rbuf[6], rbuf[7]} !== 32'hDEAD_BEEF) begin
         n_bad++;
         $display("FAIL t1_xid: got %h%h%h%h want deadbeef",
                  rbuf[4], rbuf[5], rbuf[6], rbuf[7]);
      end
      n_cmp++;
      if ({rbuf[16], rbuf[17], rbuf[18], rbuf[19]} !== 32'hA9FE_13DD) begin
         n_bad++;
         $display("FAIL t1_yiaddr: got %h%h%h%h want a9fe13dd",
                  rbuf[16], rbuf[17], rbuf[18], rbuf[19]);
      end
      n_cmp++;
      if (n_offer - o0 !== 1) begin
         n_bad++;
         $display("FAIL t1_offer_sent: got %0d pulses want 1", n_offer - o0);
      end
      n_cmp++;
      if ((n_ack - a0) + (n_nak - k0) !== 0) begin
         n_bad++;
         $display("FAIL t1_other_sent: got %0d want 0",
                  (n_ack - a0) + (n_nak - k0));
      end
      n_cmp++;
      if (dhcp_tx_request !== 1'b0) begin
         n_bad++;
         $display("FAIL t1_req_done: got %b want 0", dhcp_tx_request);
      end
   endtask

   task automatic test_nak();
      bit got;
      int k0;
      k0 = n_nak;
      build_pkt(8'h01, 8'h03, 32'h0BAD_F00D, MAC1, 1'b1, 32'h0A00_0009);
      send_pkt(250);
      rx_reply(1000, 1000, got);
      repeat (2) @(negedge clock);
      build_exp(8'h06, 32'h0BAD_F00D, MAC1, 32'h0);
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL t3_request: got %b want 1", got);
      end
      n_cmp++;
      if (count_diff() !== 0) begin
         n_bad++;
         $display("FAIL t3_reply: byte %0d got %h want %h",
                  first_diff, rbuf[first_diff], exp_b[first_diff]);
      end
      n_cmp++;
      if (rbuf[242] !== 8'h06) begin
         n_bad++;
         $display("FAIL t3_type: got %h want 06", rbuf[242]);
      end
      n_cmp++;
      if ({rbuf[16], rbuf[17], rbuf[18], rbuf[19]} !== 32'h0) begin
         n_bad++;
         $display("FAIL t3_yiaddr: got %h%h%h%h want 00000000",
                  rbuf[16], rbuf[17], rbuf[18], rbuf[19]);
      end
      n_cmp++;
      if (bound !== 1'b0) begin
         n_bad++;
         $display("FAIL t3_bound: got %b want 0", bound);
      end
      n_cmp++;
      if (n_nak - k0 !== 1) begin
         n_bad++;
         $display("FAIL t3_nak_sent: got %0d pulses want 1", n_nak - k0);
      end
   endtask

   task automatic test_ack();
      bit got;
      int a0;
      a0 = n_ack;
      build_pkt(8'h01, 8'h03, 32'h1234_5678, MAC2, 1'b1, offer_ip);
      send_pkt(250);
      rx_reply(1000, 1000, got);
      repeat (2) @(negedge clock);
      build_exp(8'h05, 32'h1234_5678, MAC2, offer_ip);
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL t2_request: got %b want 1", got);
      end
      n_cmp++;
      if (count_diff() !== 0) begin
         n_bad++;
         $display("FAIL t2_reply: byte %0d got %h want %h",
                  first_diff, rbuf[first_diff], exp_b[first_diff]);
      end
      n_cmp++;
      if (rbuf[242] !== 8'h05) begin
         n_bad++;
         $display("FAIL t2_type: got %h want 05", rbuf[242]);
      end
      n_cmp++;
      if ({rbuf[251], rbuf[252], rbuf[253], rbuf[254]} !== 32'h0001_5180) begin
         n_bad++;
         $display("FAIL t2_lease: got %h%h%h%h want 00015180",
                  rbuf[251], rbuf[252], rbuf[253], rbuf[254]);
      end
      n_cmp++;
      if (bound !== 1'b1) begin
         n_bad++;
         $display("FAIL t2_bound: got %b want 1", bound);
      end
      n_cmp++;
      if (client_mac !== MAC2) begin
         n_bad++;
         $display("FAIL t2_client_mac: got %h want %h", client_mac, MAC2);
      end
      n_cmp++;
      if (n_ack - a0 !== 1) begin
         n_bad++;
         $display("FAIL t2_ack_sent: got %0d pulses want 1", n_ack - a0);
      end
   endtask

   task automatic test_discard();
      int r0, p0;
      string nm;
      for (int c = 0; c < 4; c++) begin
         r0 = n_req;
         p0 = n_offer + n_ack + n_nak + n_drop;
         build_pkt(8'h01, 8'h01, 32'hCAFE_0000 + 32'(c), MAC1, 1'b0, 32'h0);
         unique case (c)
            0: begin pkt[238] = 8'h54; nm = "t4_cookie"; end
            1: begin pkt[0] = 8'h02; nm = "t4_op"; end
            2: nm = "t4_short";
            default: begin enable = 1'b0; nm = "t4_disabled"; end
         endcase
         send_pkt(c == 2 ? 200 : 244);
         repeat (10) @(negedge clock);
         enable = 1'b1;
         n_cmp++;
         if (n_req - r0 !== 0) begin
            n_bad++;
            $display("FAIL %s_req: got %0d request cycles want 0",
                     nm, n_req - r0);
         end
         n_cmp++;
         if ((n_offer + n_ack + n_nak + n_drop) - p0 !== 0) begin
            n_bad++;
            $display("FAIL %s_pulses: got %0d want 0", nm,
                     (n_offer + n_ack + n_nak + n_drop) - p0);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      int o0, d0, r0;
      o0 = n_offer; d0 = n_drop;
      build_pkt(8'h01, 8'h01, 32'hA5A5_0001, MAC1, 1'b0, 32'h0);
      send_pkt(244);
      build_pkt(8'h01, 8'h01, 32'h5A5A_0002, MAC2, 1'b0, 32'h0);
      fork
         rx_reply(50, 1000, got);
         send_pkt(244);
      join
      repeat (2) @(negedge clock);
      r0 = n_req;
      repeat (15) @(negedge clock);
      build_exp(8'h02, 32'hA5A5_0001, MAC1, offer_ip);
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL t5_request: got %b want 1", got);
      end
      n_cmp++;
      if (count_diff() !== 0) begin
         n_bad++;
         $display("FAIL t5_reply: byte %0d got %h want %h",
                  first_diff, rbuf[first_diff], exp_b[first_diff]);
      end
      n_cmp++;
      if (n_drop - d0 !== 1) begin
         n_bad++;
         $display("FAIL t5_dropped: got %0d pulses want 1", n_drop - d0);
      end
      n_cmp++;
      if (n_offer - o0 !== 1) begin
         n_bad++;
         $display("FAIL t5_offer_sent: got %0d pulses want 1", n_offer - o0);
      end
      n_cmp++;
      if (n_req - r0 !== 0) begin
         n_bad++;
         $display("FAIL t5_no_second: got %0d request cycles want 0",
                  n_req - r0);
      end
   endtask

   task automatic test_reset_mid_reply();
      bit got;
      int o0;
      o0 = n_offer;
      build_pkt(8'h01, 8'h01, 32'h7777_0006, MAC1, 1'b0, 32'h0);
      send_pkt(244);
      rx_reply(1000, 100, got);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (dhcp_tx_request !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_async_drop: got %b want 0", dhcp_tx_request);
      end
      udp_tx_active = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (n_offer - o0 !== 0) begin
         n_bad++;
         $display("FAIL t6_no_offer: got %0d pulses want 0", n_offer - o0);
      end
      n_cmp++;
      if (bound !== 1'b0) begin
         n_bad++;
         $display("FAIL t6_bound_cleared: got %b want 0", bound);
      end
      build_pkt(8'h01, 8'h01, 32'h8888_0007, MAC2, 1'b0, 32'h0);
      send_pkt(244);
      rx_reply(1000, 1000, got);
      repeat (2) @(negedge clock);
      build_exp(8'h02, 32'h8888_0007, MAC2, offer_ip);
      n_cmp++;
      if (got !== 1'b1) begin
         n_bad++;
         $display("FAIL t6_request: got %b want 1", got);
      end
      n_cmp++;
      if (count_diff() !== 0) begin
         n_bad++;
         $display("FAIL t6_reply: byte %0d got %h want %h",
                  first_diff, rbuf[first_diff], exp_b[first_diff]);
      end
      n_cmp++;
      if (n_offer - o0 !== 1) begin
         n_bad++;
         $display("FAIL t6_offer_sent: got %0d pulses want 1", n_offer - o0);
      end
   endtask

   initial begin
      test_reset();
      test_offer();
      test_nak();
      test_ack();
      test_discard();
      test_back_to_back();
      test_reset_mid_reply();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
